// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard/flush control bus: source operands, issue/retire events,
// branch/halt controls in; stall, enables, flush and status out.
interface hazard_ctrl_if;
    logic       rs_valid;
    logic [2:0] rs_addr;
    logic       rt_valid;
    logic [2:0] rt_addr;
    logic       iss_wr_en;
    logic [2:0] iss_wr_addr;
    logic       iss_load;
    logic       wb_wr_en;
    logic [2:0] wb_wr_addr;
    logic       kill_wr_en;
    logic [2:0] kill_wr_addr;
    logic       Branch_EXMEM;
    logic       Dump_IDEX;
    logic       stallCtrl;
    logic       pc_en;
    logic       ifid_en;
    logic       flush_ifid;
    logic       halted;
    logic       err;

    modport master (
        output rs_valid, rs_addr, rt_valid, rt_addr,
               iss_wr_en, iss_wr_addr, iss_load,
               wb_wr_en, wb_wr_addr, kill_wr_en, kill_wr_addr,
               Branch_EXMEM, Dump_IDEX,
        input  stallCtrl, pc_en, ifid_en, flush_ifid, halted, err
    );

    modport slave (
        input  rs_valid, rs_addr, rt_valid, rt_addr,
               iss_wr_en, iss_wr_addr, iss_load,
               wb_wr_en, wb_wr_addr, kill_wr_en, kill_wr_addr,
               Branch_EXMEM, Dump_IDEX,
        output stallCtrl, pc_en, ifid_en, flush_ifid, halted, err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Scoreboard-based RAW hazard stall plus RUN/FLUSH/HALT pipeline control.
// Define HAZARD_FWD_EN to replace the scoreboard stall with a 1-cycle load-use stall.
module hazard_ctrl (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      fcnt_q, fcnt_d;
    logic [7:0][1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            haz, stall, flush, halt_o, issue;

`ifdef HAZARD_FWD_EN
    logic       ld_q;
    logic [2:0] lddst_q;

    assign haz = ld_q & ((bus.rs_valid & (bus.rs_addr == lddst_q)) |
                         (bus.rt_valid & (bus.rt_addr == lddst_q)));

    // The stalled consumer cannot issue, so the flag clears after one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_q    <= 1'b0;
            lddst_q <= 3'd0;
        end else begin
            ld_q    <= issue & bus.iss_load;
            lddst_q <= issue ? bus.iss_wr_addr : 3'd0;
        end
    end
`else
    assign haz = (bus.rs_valid & (cnt_q[bus.rs_addr] != 2'd0)) |
                 (bus.rt_valid & (cnt_q[bus.rt_addr] != 2'd0));
`endif

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        stall   = haz;
        flush   = 1'b0;
        halt_o  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.Dump_IDEX) begin
                    state_d = HALT;
                end else if (bus.Branch_EXMEM) begin
                    state_d = FLUSH;
                    fcnt_d  = 2'd2;
                end
            end
            FLUSH: begin
                // The IF/ID contents are being squashed, so they must not hold the pipe.
                flush = 1'b1;
                stall = 1'b0;
                if (bus.Dump_IDEX) begin
                    state_d = HALT;
                    fcnt_d  = 2'd0;
                end else if (bus.Branch_EXMEM) begin
                    fcnt_d = 2'd2;
                end else if (fcnt_q <= 2'd1) begin
                    state_d = RUN;
                    fcnt_d  = 2'd0;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
            HALT: begin
                stall  = 1'b1;
                halt_o = 1'b1;
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 2'd0;
            end
        endcase
    end

    assign issue = bus.iss_wr_en & ~stall & ~flush & (state_q == RUN);

    // Per-register net change; saturation at either end is flagged as an error.
    always_comb begin
        logic signed [3:0] s;
        cnt_d = cnt_q;
        err_d = err_q;
        s     = 4'sd0;
        for (int i = 0; i < 8; i++) begin
            s = $signed({2'b00, cnt_q[i]});
            if (issue && (bus.iss_wr_addr == 3'(i)))       s = s + 4'sd1;
            if (bus.wb_wr_en && (bus.wb_wr_addr == 3'(i)))     s = s - 4'sd1;
            if (bus.kill_wr_en && (bus.kill_wr_addr == 3'(i))) s = s - 4'sd1;
            if (s > 4'sd3) begin
                cnt_d[i] = 2'd3;
                err_d    = 1'b1;
            end else if (s < 4'sd0) begin
                cnt_d[i] = 2'd0;
                err_d    = 1'b1;
            end else begin
                cnt_d[i] = s[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= 2'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.stallCtrl  = stall;
    assign bus.pc_en      = ~stall;
    assign bus.ifid_en    = ~stall;
    assign bus.flush_ifid = flush;
    assign bus.halted     = halt_o;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a per-register pending-count model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    hazard_ctrl_if bus ();

    hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: pending writers per register, flush cycles left, halt/error flags.
    int mcnt[8];
    int mflush_left;
    bit mhalt, merr, mld;
    int mlddst;

    function automatic void m_reset();
        for (int r = 0; r < 8; r++) mcnt[r] = 0;
        mflush_left = 0; mhalt = 0; merr = 0; mld = 0; mlddst = 0;
    endfunction

    function automatic bit m_haz();
`ifdef HAZARD_FWD_EN
        return mld && ((bus.rs_valid && bus.rs_addr == mlddst) ||
                       (bus.rt_valid && bus.rt_addr == mlddst));
`else
        return (bus.rs_valid && mcnt[bus.rs_addr] != 0) ||
               (bus.rt_valid && mcnt[bus.rt_addr] != 0);
`endif
    endfunction

    function automatic bit m_flush();
        return !mhalt && mflush_left > 0;
    endfunction

    function automatic bit m_stall();
        if (!rst) return 0;
        if (mhalt) return 1;
        if (mflush_left > 0) return 0;
        return m_haz();
    endfunction

    task automatic clr_in();
        bus.rs_valid = 0; bus.rs_addr = 0; bus.rt_valid = 0; bus.rt_addr = 0;
        bus.iss_wr_en = 0; bus.iss_wr_addr = 0; bus.iss_load = 0;
        bus.wb_wr_en = 0; bus.wb_wr_addr = 0; bus.kill_wr_en = 0; bus.kill_wr_addr = 0;
        bus.Branch_EXMEM = 0; bus.Dump_IDEX = 0;
    endtask

    // Advance model and DUT by one clock; returns at the following falling edge.
    task automatic tick();
        bit iss;
        int v;
        int ncnt[8];
        bit nerr_f;
        iss = bus.iss_wr_en && !m_stall() && !m_flush() && !mhalt;
        nerr_f = merr;
        for (int r = 0; r < 8; r++) begin
            v = mcnt[r];
            if (iss && bus.iss_wr_addr == r) v++;
            if (bus.wb_wr_en && bus.wb_wr_addr == r) v--;
            if (bus.kill_wr_en && bus.kill_wr_addr == r) v--;
            if (v > 3) begin v = 3; nerr_f = 1; end
            if (v < 0) begin v = 0; nerr_f = 1; end
            ncnt[r] = v;
        end
        @(posedge clk);
        for (int r = 0; r < 8; r++) mcnt[r] = ncnt[r];
        merr = nerr_f;
        mld = iss && bus.iss_load;
        mlddst = iss ? int'(bus.iss_wr_addr) : 0;
        if (!mhalt) begin
            if (bus.Dump_IDEX) begin mhalt = 1; mflush_left = 0; end
            else if (bus.Branch_EXMEM) mflush_left = 2;
            else if (mflush_left > 0) mflush_left--;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_in();
        rst = 0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        clr_in();
        bus.rs_valid = 1; bus.rt_valid = 1; bus.iss_wr_en = 1;
        m_reset();
        #1;
        nvec++; if (bus.stallCtrl !== 1'b0) begin $display("FAIL reset_stall got %b want 0", bus.stallCtrl); nerr++; end
        nvec++; if (bus.pc_en !== 1'b1 || bus.ifid_en !== 1'b1) begin $display("FAIL reset_en got %b%b want 11", bus.pc_en, bus.ifid_en); nerr++; end
        nvec++; if ({bus.flush_ifid, bus.halted, bus.err} !== 3'b000) begin $display("FAIL reset_flags got %b want 000", {bus.flush_ifid, bus.halted, bus.err}); nerr++; end
        do_reset();
    endtask

    task automatic test_raw_stall();
        clr_in();
        bus.iss_wr_en = 1; bus.iss_wr_addr = 3;
        tick();
        clr_in();
        bus.rs_valid = 1; bus.rs_addr = 3;
        #1;
        nvec++; if (bus.stallCtrl !== 1'b1 || bus.pc_en !== 1'b0) begin $display("FAIL raw_stall got stall=%b pc_en=%b want 1/0", bus.stallCtrl, bus.pc_en); nerr++; end
        bus.wb_wr_en = 1; bus.wb_wr_addr = 3;
        tick();
        bus.wb_wr_en = 0;
        #1;
        nvec++; if (bus.stallCtrl !== 1'b0 || bus.ifid_en !== 1'b1) begin $display("FAIL raw_release got stall=%b ifid_en=%b want 0/1", bus.stallCtrl, bus.ifid_en); nerr++; end
    endtask

    task automatic test_flush();
        bit exp_f[7] = '{0, 1, 1, 1, 1, 0, 0};
        do_reset();
        clr_in();
        bus.iss_wr_en = 1; bus.iss_wr_addr = 6;
        tick();
        clr_in();
        bus.rs_valid = 1; bus.rs_addr = 6;
        // Branch pulse in cycle 0, second pulse in the second flush cycle (cycle 2).
        for (int c = 0; c < 7; c++) begin
            bus.Branch_EXMEM = (c == 0 || c == 2);
            #1;
            nvec++; if (bus.flush_ifid !== exp_f[c]) begin $display("FAIL flush_c%0d got %b want %b", c, bus.flush_ifid, exp_f[c]); nerr++; end
            nvec++; if (bus.stallCtrl !== !exp_f[c]) begin $display("FAIL flush_stall_c%0d got %b want %b", c, bus.stallCtrl, !exp_f[c]); nerr++; end
            tick();
        end
        clr_in();
        bus.wb_wr_en = 1; bus.wb_wr_addr = 6;
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        clr_in();
        bus.iss_wr_en = 1; bus.iss_wr_addr = 5;
        for (int k = 1; k <= 4; k++) begin
            tick();
            #1;
            nvec++; if (bus.err !== (k == 4)) begin $display("FAIL sat_err_issue%0d got %b want %b", k, bus.err, k == 4); nerr++; end
        end
        clr_in();
        bus.wb_wr_en = 1; bus.wb_wr_addr = 5;
        bus.rs_valid = 1; bus.rs_addr = 5;
        for (int k = 1; k <= 3; k++) begin
            tick();
            #1;
            nvec++; if (bus.stallCtrl !== (k < 3)) begin $display("FAIL sat_drain%0d got %b want %b", k, bus.stallCtrl, k < 3); nerr++; end
        end
        nvec++; if (bus.err !== 1'b1) begin $display("FAIL sat_err_sticky got %b want 1", bus.err); nerr++; end
    endtask

    task automatic test_same_cycle();
        do_reset();
        clr_in();
        bus.iss_wr_en = 1; bus.iss_wr_addr = 2;
        tick();
        bus.wb_wr_en = 1; bus.wb_wr_addr = 2;
        tick();
        clr_in();
        bus.rs_valid = 1; bus.rs_addr = 2;
        #1;
        nvec++; if (bus.stallCtrl !== 1'b1 || bus.err !== 1'b0) begin $display("FAIL same_iss_wb got stall=%b err=%b want 1/0", bus.stallCtrl, bus.err); nerr++; end
        bus.wb_wr_en = 1; bus.wb_wr_addr = 2;
        bus.kill_wr_en = 1; bus.kill_wr_addr = 2;
        tick();
        bus.wb_wr_en = 0; bus.kill_wr_en = 0;
        #1;
        nvec++; if (bus.stallCtrl !== 1'b0 || bus.err !== 1'b1) begin $display("FAIL same_wb_kill got stall=%b err=%b want 0/1", bus.stallCtrl, bus.err); nerr++; end
    endtask

    task automatic test_halt();
        do_reset();
        clr_in();
        bus.Dump_IDEX = 1; bus.Branch_EXMEM = 1;
        tick();
        clr_in();
        for (int c = 0; c < 3; c++) begin
            bus.Branch_EXMEM = (c == 1);
            #1;
            nvec++; if ({bus.halted, bus.stallCtrl, bus.flush_ifid, bus.pc_en} !== 4'b1100) begin
                $display("FAIL halt_c%0d got h/s/f/pc=%b want 1100", c, {bus.halted, bus.stallCtrl, bus.flush_ifid, bus.pc_en}); nerr++; end
            tick();
        end
        #2;
        rst = 0;
        m_reset();
        #1;
        nvec++; if ({bus.halted, bus.stallCtrl, bus.flush_ifid, bus.err, bus.pc_en, bus.ifid_en} !== 6'b000011) begin
            $display("FAIL halt_async_rst got %b want 000011", {bus.halted, bus.stallCtrl, bus.flush_ifid, bus.err, bus.pc_en, bus.ifid_en}); nerr++; end
        @(negedge clk);
        rst = 1;
        bus.iss_wr_en = 1; bus.iss_wr_addr = 7;
        tick();
        clr_in();
        bus.rt_valid = 1; bus.rt_addr = 7;
        #1;
        nvec++; if (bus.halted !== 1'b0 || bus.stallCtrl !== m_stall()) begin $display("FAIL post_rst_run got h=%b s=%b want 0/%b", bus.halted, bus.stallCtrl, m_stall()); nerr++; end
    endtask

`ifdef HAZARD_FWD_EN
    task automatic test_fwd();
        do_reset();
        clr_in();
        bus.iss_wr_en = 1; bus.iss_wr_addr = 4; bus.iss_load = 1;
        tick();
        clr_in();
        bus.rt_valid = 1; bus.rt_addr = 4;
        #1;
        nvec++; if (bus.stallCtrl !== 1'b1) begin $display("FAIL fwd_load_stall got %b want 1", bus.stallCtrl); nerr++; end
        tick();
        nvec++; if (bus.stallCtrl !== 1'b0) begin $display("FAIL fwd_load_one got %b want 0", bus.stallCtrl); nerr++; end
        clr_in();
        bus.iss_wr_en = 1; bus.iss_wr_addr = 4;
        tick();
        clr_in();
        bus.rt_valid = 1; bus.rt_addr = 4;
        #1;
        nvec++; if (bus.stallCtrl !== 1'b0) begin $display("FAIL fwd_alu got %b want 0", bus.stallCtrl); nerr++; end
    endtask
`endif

    task automatic test_random(input int n, input int dump_pct);
        do_reset();
        for (int c = 0; c < n; c++) begin
            bus.rs_valid     = ($urandom_range(0, 99) < 60);
            bus.rs_addr      = 3'($urandom_range(0, 7));
            bus.rt_valid     = ($urandom_range(0, 99) < 60);
            bus.rt_addr      = 3'($urandom_range(0, 7));
            bus.iss_wr_en    = ($urandom_range(0, 99) < 50);
            bus.iss_wr_addr  = 3'($urandom_range(0, 7));
            bus.iss_load     = ($urandom_range(0, 99) < 40);
            bus.wb_wr_en     = ($urandom_range(0, 99) < 40);
            bus.wb_wr_addr   = 3'($urandom_range(0, 7));
            bus.kill_wr_en   = ($urandom_range(0, 99) < 10);
            bus.kill_wr_addr = 3'($urandom_range(0, 7));
            bus.Branch_EXMEM = ($urandom_range(0, 99) < 8);
            bus.Dump_IDEX    = ($urandom_range(0, 999) < dump_pct * 10);
            #1;
            nvec++; if (bus.stallCtrl !== m_stall()) begin $display("FAIL rnd_stall c%0d got %b want %b", c, bus.stallCtrl, m_stall()); nerr++; end
            nvec++; if (bus.pc_en !== !m_stall() || bus.ifid_en !== !m_stall()) begin $display("FAIL rnd_en c%0d got %b%b want %b", c, bus.pc_en, bus.ifid_en, !m_stall()); nerr++; end
            nvec++; if (bus.flush_ifid !== m_flush()) begin $display("FAIL rnd_flush c%0d got %b want %b", c, bus.flush_ifid, m_flush()); nerr++; end
            nvec++; if (bus.halted !== mhalt || bus.err !== merr) begin $display("FAIL rnd_flags c%0d got h=%b e=%b want %b/%b", c, bus.halted, bus.err, mhalt, merr); nerr++; end
            tick();
        end
    endtask

    initial begin
        clr_in();
        test_reset();
        test_raw_stall();
        test_flush();
        test_saturate();
        test_same_cycle();
        test_halt();
`ifdef HAZARD_FWD_EN
        test_fwd();
`endif
        test_random(400, 0);
        test_random(300, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, with ports listed as follows.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
REQ-002 Source-operand ports SHALL be:
- rs_valid  input  1  IF/ID instr reads instr[10:8]
- rs_addr  input  3
- rt_valid  input  1  IF/ID instr reads instr[7:5]
- rt_addr  input  3
REQ-003 Issue and retire ports SHALL be:
- iss_wr_en  input  1  IF/ID instr will write a register
- iss_wr_addr  input  3  its WrR
- iss_load  input  1  IF/ID instr is a load (MemRead)
- wb_wr_en  input  1  MEM/WB write committing this cycle
- wb_wr_addr  input  3
- kill_wr_en  input  1  in-flight writer squashed
- kill_wr_addr  input  3
REQ-004 Control ports SHALL be:
- Branch_EXMEM  input  1  taken branch/jump resolved
- Dump_IDEX  input  1  halt in ID/EX
- stallCtrl  output  1  to decode (bubble)
- pc_en  output  1  PC write enable
- ifid_en  output  1  IF/ID register enable
- flush_ifid  output  1  squash IF/ID contents
- halted  output  1
- err  output  1  sticky scoreboard error

Function
REQ-005 The block SHALL hold an 8-entry scoreboard of 2-bit pending-writer counts, one per register R0-R7.
REQ-006 "issue" SHALL be iss_wr_en & ~stallCtrl & ~flush_ifid & state==RUN. Each issue SHALL increment cnt[iss_wr_addr] at the next clk edge.
REQ-007 Each wb_wr_en SHALL decrement cnt[wb_wr_addr], and each kill_wr_en SHALL decrement cnt[kill_wr_addr], at the next edge.
REQ-008 Simultaneous events on the same register SHALL sum. Examples: +1-1 = unchanged; -1-1 = -2.
REQ-009 A count that would go above 3 or below 0 SHALL saturate (3 or 0), and err SHALL set to 1 and stay set until reset.
REQ-010 The hazard stall term SHALL be combinational: (rs_valid & cnt[rs_addr]!=0) | (rt_valid & cnt[rt_addr]!=0).
REQ-011 stallCtrl SHALL be the hazard stall term OR (state==HALT), and pc_en = ifid_en = ~stallCtrl.
REQ-012 The FSM SHALL have states RUN, FLUSH, HALT.
REQ-013 RUN to FLUSH: on Branch_EXMEM; the 2-bit flush counter loads 2.
REQ-014 FLUSH: flush_ifid=1; counter decrements each cycle; FLUSH to RUN when the counter reaches 0 (exactly 2 flush cycles).
REQ-015 Branch_EXMEM asserted in FLUSH SHALL reload the counter to 2.
REQ-016 RUN or FLUSH to HALT: on Dump_IDEX. Dump_IDEX SHALL have priority over Branch_EXMEM in the same cycle.
REQ-017 HALT SHALL be absorbing until reset: halted=1, stallCtrl=1, flush_ifid=0.
REQ-018 In FLUSH, stallCtrl SHALL be 0 (flush overrides stall), so a squashed IF/ID instruction never holds the pipe.
REQ-019 wb/kill decrements SHALL continue in every state, so in-flight writers drain during FLUSH and HALT.

Reset
REQ-020 While rst=0, asynchronously: all counts=0, state=RUN, flush counter=0, err=0, halted=0, flush_ifid=0.
REQ-021 While rst=0, stallCtrl=0 and pc_en=ifid_en=1.
REQ-022 Reset asserted mid-FLUSH or mid-HALT SHALL return to RUN. The first edge after rst rises SHALL be a normal RUN cycle.

Configuration
REQ-023 Macro HAZARD_FWD_EN SHALL select the stall rule.
- Defined: the scoreboard stall term is replaced by a load-use check. A 1-bit ldflag plus 3-bit lddst record the issuing instruction's iss_load/iss_wr_addr each edge (cleared when no issue). Stall = ldflag & ((rs_valid & rs_addr==lddst) | (rt_valid & rt_addr==lddst)), for exactly 1 cycle. Scoreboard counts and err SHALL still be maintained.
- Undefined: REQ-010 applies, with no ldflag logic.

Verification
REQ-024 Issue write R3, then next cycle rs_addr=3 rs_valid=1 -> stallCtrl=1, pc_en=0; after wb_wr_en addr 3 -> cnt[3]=0, stallCtrl=0 the same cycle after the edge.
REQ-025 Branch_EXMEM pulse for 1 cycle -> flush_ifid=1 for exactly 2 cycles, stallCtrl=0 during them; a second pulse in cycle 2 -> 2 further flush cycles.
REQ-026 Four issues to R5 with no retire -> cnt[5]=3, err=1 after the 4th edge; err stays 1 after R5 drains to 0.
REQ-027 Issue R2 and wb R2 in the same cycle with cnt[2]=1 -> cnt[2]=1; then wb R2 plus kill R2 -> cnt[2]=0 and err=1.
REQ-028 Dump_IDEX and Branch_EXMEM together -> HALT, halted=1, stallCtrl=1, flush_ifid=0; rst=0 mid-HALT -> all outputs at reset values immediately, without waiting for a clk edge.
REQ-029 With HAZARD_FWD_EN defined: a load to R4 followed by rt_addr=4 -> exactly 1 stall cycle; an ALU write to R4 followed by rt_addr=4 -> 0 stall cycles.
